bus_tx_framer: RTL and testbench

Upstream transmit stage for one bus endpoint, feeding the `data_bus` send port (`send_valid`/`send_data`/`send_ready`/`ack`). It buffers payload bytes from the local engine in a byte FIFO and accepts a transfer request (destination, opcode, length). It then emits one header byte followed by exactly `length` payload bytes under the `send_ready` handshake, and pulses `ack` to release the bus. A stall timer aborts transfers the bus never grants.

---
 rtl/bus_pkg.sv | 39 +++
 rtl/byte_fifo.sv | 74 +++++++
 rtl/bus_tx_framer.sv | 214 +++++++++++++++++++++
 tb/tb_bus_tx_framer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the data_bus endpoint transmit path.
//   state_t      : transmit framer FSM states
//   HDR_*        : bit positions of the header fields
//   CONTROL_ID   : reserved controller endpoint ID
//   NO_OWNER     : arbiter encoding for "bus not owned"
//   make_header  : packs destination/source/opcode into a header byte
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    PAY   = 3'd2,
    ACK   = 3'd3,
    ABORT = 3'd4
  } state_t;

  // Header layout: {2'b00, dest[1:0], src[1:0], op[1:0]}
  localparam int HDR_OP  = 0;
  localparam int HDR_SRC = 2;
  localparam int HDR_DST = 4;

  localparam logic [1:0] CONTROL_ID = 2'b11;
  localparam logic [2:0] NO_OWNER   = 3'd7;

  function automatic logic [7:0] make_header(input logic [1:0] dest,
                                             input logic [1:0] src,
                                             input logic [1:0] op);
    logic [7:0] hdr;
    hdr                = 8'h00;
    hdr[HDR_DST +: 2]  = dest;
    hdr[HDR_SRC +: 2]  = src;
    hdr[HDR_OP  +: 2]  = op;
    return hdr;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO with first-word-fall-through head and occupancy count.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset (flushes pointers)
//   i_push, i_data   : write strobe and byte; ignored while full
//   i_pop            : remove head byte; ignored while empty
//   o_head           : current head byte (valid while o_count != 0)
//   o_count          : number of stored bytes, 0..DEPTH
//   o_full           : o_count == DEPTH
// -----------------------------------------------------------------------------
module byte_fifo
  import bus_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic [LW-1:0] o_count,
  output logic          o_full
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Qualify strobes so a misbehaving caller can never corrupt the count.
  always_comb begin
    w_push = i_push && (r_count != LW'(DEPTH));
    w_pop  = i_pop  && (r_count != LW'(0));
  end

  // Byte storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= LW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == LW'(DEPTH));

endmodule

// File: rtl/bus_tx_framer.sv
// -----------------------------------------------------------------------------
// bus_tx_framer
// Transmit stage for one data_bus endpoint. Buffers payload bytes, admits a
// transfer request only once the whole payload is buffered, then sends one
// header byte plus `len` payload bytes under the send_ready handshake and
// pulses ack to release the bus. A stall timer aborts transfers that the bus
// never grants and discards their unsent payload.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_my_id                      : this endpoint's static ID (header source)
//   i_wr_valid, i_wr_data        : payload byte write; o_wr_ready = not full
//   i_req_valid/_dest/_op/_len   : transfer request; o_req_ready = accepted
//   o_send_valid, o_send_data    : byte offered to the bus
//   i_send_ready                 : bus takes the byte this cycle
//   o_ack                        : one-cycle end-of-transfer / bus release
//   o_busy                       : FSM not idle
//   o_done                       : normal completion pulse (with o_ack)
//   o_err                        : rejected request or aborted transfer pulse
// -----------------------------------------------------------------------------
module bus_tx_framer
  import bus_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 64,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1:0]    i_my_id,
  input  logic          i_wr_valid,
  input  logic [7:0]    i_wr_data,
  output logic          o_wr_ready,
  input  logic          i_req_valid,
  input  logic [1:0]    i_req_dest,
  input  logic [1:0]    i_req_op,
  input  logic [LW-1:0] i_req_len,
  output logic          o_req_ready,
  output logic          o_send_valid,
  output logic [7:0]    o_send_data,
  input  logic          i_send_ready,
  output logic          o_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int SW = $clog2(TIMEOUT + 1);

  state_t        r_state;
  logic [7:0]    r_hdr;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_remaining;
  logic [SW-1:0] r_stall;
  logic          r_send_valid;
  logic          r_ack;
  logic          r_done;
  logic          r_err;
  logic          r_busy;

  logic [7:0]    w_head;
  logic [LW-1:0] w_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_beat;
  logic          w_req_fire;
  logic          w_req_bad;
  logic          w_stall_hit;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // Handshake decode, admission check and stall detection.
  always_comb begin
    w_push = i_wr_valid && !w_full;
    w_beat = r_send_valid && i_send_ready;
    // Held low during reset so admission is first evaluated after rst drops.
    if (!i_rst && (r_state == IDLE)) begin
      o_req_ready = (i_req_len == LW'(0)) || (w_count >= i_req_len);
    end else begin
      o_req_ready = 1'b0;
    end
    w_req_fire = i_req_valid && o_req_ready;
    w_req_bad  = (i_req_len == LW'(0)) || (i_req_len > LW'(DEPTH));
    // The stall that brings the counter up to TIMEOUT triggers the abort.
    w_stall_hit = r_send_valid && !i_send_ready && (r_stall == SW'(TIMEOUT - 1));
    if (r_state == ABORT) begin
      w_pop = 1'b1;
    end else begin
      w_pop = (r_state == PAY) && w_beat;
    end
  end

  // Output byte mux: only registered header and FIFO storage feed send_data.
  always_comb begin
    case (r_state)
      HDR:     o_send_data = r_hdr;
      PAY:     o_send_data = w_head;
      default: o_send_data = 8'h00;
    endcase
  end

  // Framer FSM with registered handshake and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_hdr        <= 8'h00;
      r_len        <= LW'(0);
      r_remaining  <= LW'(0);
      r_stall      <= SW'(0);
      r_send_valid <= 1'b0;
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            if (w_req_bad) begin
              r_err <= 1'b1;
            end else begin
              r_hdr        <= make_header(i_req_dest, i_my_id, i_req_op);
              r_len        <= i_req_len;
              r_stall      <= SW'(0);
              r_send_valid <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= HDR;
            end
          end
        end
        HDR: begin
          if (w_beat) begin
            r_remaining <= r_len;
            r_stall     <= SW'(0);
            r_state     <= PAY;
          end else if (w_stall_hit) begin
            // Nothing sent yet: the whole payload must be discarded.
            r_remaining  <= r_len;
            r_stall      <= SW'(TIMEOUT);
            r_send_valid <= 1'b0;
            r_ack        <= 1'b1;
            r_err        <= 1'b1;
            r_state      <= ABORT;
          end else if (r_stall != SW'(TIMEOUT)) begin
            r_stall <= r_stall + SW'(1);
          end else begin
            r_stall <= r_stall;
          end
        end
        PAY: begin
          if (w_beat) begin
            r_stall     <= SW'(0);
            r_remaining <= r_remaining - LW'(1);
            if (r_remaining == LW'(1)) begin
              r_send_valid <= 1'b0;
              r_ack        <= 1'b1;
              r_done       <= 1'b1;
              r_state      <= ACK;
            end
          end else if (w_stall_hit) begin
            r_stall      <= SW'(TIMEOUT);
            r_send_valid <= 1'b0;
            r_ack        <= 1'b1;
            r_err        <= 1'b1;
            r_state      <= ABORT;
          end else if (r_stall != SW'(TIMEOUT)) begin
            r_stall <= r_stall + SW'(1);
          end else begin
            r_stall <= r_stall;
          end
        end
        ACK: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        ABORT: begin
          // One unsent byte leaves the FIFO per cycle.
          r_remaining <= r_remaining - LW'(1);
          if (r_remaining == LW'(1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_send_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign o_wr_ready   = !w_full;
  assign o_send_valid = r_send_valid;
  assign o_ack        = r_ack;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_bus_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_bus_tx_framer
// Self-checking bench for bus_tx_framer. The reference model is a byte queue
// holding what the FIFO should contain; each transfer is predicted cycle by
// cycle from the handshake rules (header, then queue front per beat, ack
// after the last beat, abort after TIMEOUT consecutive refused cycles).
// -----------------------------------------------------------------------------
module tb_bus_tx_framer;

  localparam int         DEPTH   = 16;
  localparam int         TIMEOUT = 8;
  localparam int         LW      = $clog2(DEPTH) + 1;
  localparam logic [1:0] MY_ID   = 2'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    my_id;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          req_valid;
  logic [1:0]    req_dest;
  logic [1:0]    req_op;
  logic [LW-1:0] req_len;
  logic          req_ready;
  logic          send_valid;
  logic [7:0]    send_data;
  logic          send_ready;
  logic          ack;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  bus_tx_framer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_my_id      (my_id),
    .i_wr_valid   (wr_valid),
    .i_wr_data    (wr_data),
    .o_wr_ready   (wr_ready),
    .i_req_valid  (req_valid),
    .i_req_dest   (req_dest),
    .i_req_op     (req_op),
    .i_req_len    (req_len),
    .o_req_ready  (req_ready),
    .o_send_valid (send_valid),
    .o_send_data  (send_data),
    .i_send_ready (send_ready),
    .o_ack        (ack),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge. Sample point: falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".send_valid"}, send_valid, 1'b0);
    chk({tag, ".send_data"}, send_data, 8'h00);
    chk({tag, ".ack"}, ack, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".err"}, err, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    smp();
    chk("wr_ready", wr_ready, (q.size() < DEPTH));
    cyc();
    if (q.size() < DEPTH) q.push_back(b);
    wr_valid = 1'b0;
  endtask

  // Observe the FIFO count through admission: count+1 refused, count accepted.
  task automatic probe_count(input string tag);
    req_valid = 1'b0;
    if (q.size() < DEPTH) begin
      req_len = LW'(q.size() + 1);
      smp();
      chk({tag, ".count_short"}, req_ready, 1'b0);
      cyc();
    end
    if (q.size() > 0) begin
      req_len = LW'(q.size());
      smp();
      chk({tag, ".count_exact"}, req_ready, 1'b1);
      cyc();
    end
  endtask

  // One full transfer. hold_low: refused cycles from the header on;
  // stuck_after: send_ready stays low once that many beats (header counts)
  // are done; rdy_pct: acceptance probability otherwise; bg_wr: random
  // payload writes while the transfer is in flight.
  task automatic transfer(input string tag, input logic [1:0] dest, input logic [1:0] op,
                          input int len, input int hold_low, input int stuck_after,
                          input int rdy_pct, input bit bg_wr, output bit was_aborted);
    logic [7:0] hdr;
    logic [7:0] wd;
    int         beats;
    int         stall;
    int         rem;
    bit         aborted;
    bit         fin;
    bit         pushed;
    bit         wr_ok;
    hdr       = {2'b00, dest, MY_ID, op};
    req_valid = 1'b1;
    req_dest  = dest;
    req_op    = op;
    req_len   = LW'(len);
    smp();
    chk({tag, ".req_ready"}, req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    beats   = 0;
    stall   = 0;
    aborted = 1'b0;
    fin     = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (hold_low > 0) begin
        send_ready = 1'b0;
        hold_low--;
      end else if (beats >= stuck_after) begin
        send_ready = 1'b0;
      end else begin
        send_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      pushed   = bg_wr && ($urandom_range(0, 3) == 0);
      wd       = 8'($urandom);
      wr_valid = pushed;
      wr_data  = wd;
      wr_ok    = (q.size() < DEPTH);
      smp();
      chk({tag, ".send_valid"}, send_valid, 1'b1);
      chk({tag, ".send_data"}, send_data, (beats == 0) ? hdr : q[0]);
      chk({tag, ".ack_in_flight"}, ack, 1'b0);
      chk({tag, ".busy"}, busy, 1'b1);
      if (pushed) chk({tag, ".bg_wr_ready"}, wr_ready, wr_ok);
      cyc();
      if (send_ready) begin
        if (beats > 0) void'(q.pop_front());
        beats++;
        stall = 0;
      end else begin
        stall++;
      end
      if (pushed && wr_ok) q.push_back(wd);
      if (beats == len + 1) begin
        fin = 1'b1;
      end else if (stall == TIMEOUT) begin
        aborted = 1'b1;
        fin     = 1'b1;
      end
    end
    wr_valid   = 1'b0;
    send_ready = 1'b0;
    chk({tag, ".within_budget"}, fin, 1'b1);
    smp();
    chk({tag, ".ack"}, ack, 1'b1);
    chk({tag, ".done"}, done, !aborted);
    chk({tag, ".err"}, err, aborted);
    chk({tag, ".ack_send_valid"}, send_valid, 1'b0);
    chk({tag, ".ack_busy"}, busy, 1'b1);
    cyc();
    if (aborted) begin
      rem = len - ((beats > 0) ? beats - 1 : 0);
      for (int i = 1; i < rem; i++) begin
        smp();
        chk({tag, ".drain_ack"}, ack, 1'b0);
        chk({tag, ".drain_err"}, err, 1'b0);
        chk({tag, ".drain_busy"}, busy, 1'b1);
        cyc();
      end
      repeat (rem) void'(q.pop_front());
    end
    smp();
    chk_quiet({tag, ".idle"});
    cyc();
    was_aborted = aborted;
  endtask

  initial begin
    bit ab;
    int n;
    int len;
    rst        = 1'b1;
    my_id      = MY_ID;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    req_valid  = 1'b0;
    req_dest   = 2'd0;
    req_op     = 2'd0;
    req_len    = LW'(0);
    send_ready = 1'b0;

    // Reset state (req_len = 0 would be admissible if reset did not mask it)
    cyc();
    smp();
    chk_quiet("reset");
    chk("reset.wr_ready", wr_ready, 1'b1);
    chk("reset.req_ready", req_ready, 1'b0);
    cyc();
    rst = 1'b0;

    // Basic transfer: header 0x25 then A0..A2
    write_byte(8'hA0);
    write_byte(8'hA1);
    write_byte(8'hA2);
    transfer("basic", 2'd2, 2'd1, 3, 0, 99, 100, 1'b0, ab);
    chk("basic.hdr_const", {2'b00, 2'd2, MY_ID, 2'd1}, 8'h25);

    // Backpressure: header refused for 3 cycles
    write_byte(8'hB0);
    write_byte(8'hB1);
    write_byte(8'hB2);
    transfer("backpressure", 2'd2, 2'd1, 3, 3, 99, 100, 1'b0, ab);

    // Admission: len 4 needs 4 buffered bytes
    write_byte(8'hC0);
    write_byte(8'hC1);
    req_len = LW'(4);
    smp();
    chk("admit.two", req_ready, (q.size() >= 4));
    cyc();
    write_byte(8'hC2);
    req_len = LW'(4);
    smp();
    chk("admit.three", req_ready, (q.size() >= 4));
    cyc();
    write_byte(8'hC3);
    req_len = LW'(4);
    smp();
    chk("admit.four", req_ready, (q.size() >= 4));
    cyc();
    transfer("admit", 2'd3, 2'd2, 4, 0, 99, 100, 1'b0, ab);

    // Zero-length request is accepted and rejected with err, no bus activity
    write_byte(8'hD0);
    req_valid = 1'b1;
    req_len   = LW'(0);
    smp();
    chk("zero.req_ready", req_ready, 1'b1);
    cyc();
    req_valid = 1'b0;
    smp();
    chk("zero.err", err, 1'b1);
    chk("zero.send_valid", send_valid, 1'b0);
    chk("zero.busy", busy, 1'b0);
    chk("zero.ack", ack, 1'b0);
    cyc();
    smp();
    chk_quiet("zero.after");
    cyc();
    probe_count("zero");

    // Timeout: 2 of 5 payload bytes sent, then bus stuck; 3 bytes discarded
    for (int i = 0; i < 5; i++) write_byte(8'hE0 + 8'(i));
    transfer("timeout", 2'd0, 2'd3, 5, 0, 3, 100, 1'b0, ab);
    chk("timeout.aborted", ab, 1'b1);
    probe_count("timeout");

    // FIFO full, then wrap
    while (q.size() < DEPTH) write_byte(8'h40 + 8'(q.size()));
    write_byte(8'hFF);
    transfer("wrap10", 2'd1, 2'd0, 10, 0, 99, 100, 1'b0, ab);
    for (int i = 0; i < 10; i++) write_byte(8'h80 + 8'(i));
    chk("wrap.model_full", q.size(), DEPTH);
    transfer("wrap16", 2'd2, 2'd3, 16, 0, 99, 100, 1'b0, ab);
    probe_count("wrap");

    // Randomized transfers with random backpressure and concurrent writes
    for (int it = 0; it < 24; it++) begin
      n = $urandom_range(0, DEPTH - q.size());
      for (int i = 0; i < n; i++) write_byte(8'($urandom));
      if (q.size() == 0) write_byte(8'($urandom));
      len = $urandom_range(1, q.size());
      transfer("rand", 2'($urandom), 2'($urandom), len, $urandom_range(0, 2), 99,
               $urandom_range(50, 100), 1'b1, ab);
      if (it % 6 == 5) probe_count("rand");
    end

    // Reset mid-PAY after 2 of 5 payload bytes
    while (q.size() < 5) write_byte(8'($urandom));
    req_valid  = 1'b1;
    req_dest   = 2'd3;
    req_op     = 2'd2;
    req_len    = LW'(5);
    smp();
    chk("rstpay.req_ready", req_ready, 1'b1);
    cyc();
    req_valid  = 1'b0;
    send_ready = 1'b1;
    smp();
    chk("rstpay.hdr", send_data, {2'b00, 2'd3, MY_ID, 2'd2});
    cyc();
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("rstpay.byte", send_data, q[0]);
      cyc();
      void'(q.pop_front());
    end
    rst = 1'b1;
    smp();
    chk("rstpay.during_ack", ack, 1'b0);
    cyc();
    rst        = 1'b0;
    send_ready = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk_quiet("rstpay.after");
      chk("rstpay.wr_ready", wr_ready, 1'b1);
      cyc();
    end
    probe_count("rstpay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
